// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states and instruction width.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LD  = 2'b01,
    OP_ST  = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_MEM    = 2'b10,
    S_WB     = 2'b11
  } state_e;

  // Instruction layout is op(2) | rs | rt | rd/imm, each field RA_W wide.
  function automatic int instr_w(input int ra_w);
    return 2 + 3 * ra_w;
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction/data memory handshakes plus PC and write-back observation signals.
interface multicycle_core_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) ();
  localparam int INSTR_W = instr_w(RA_W);

  logic               imem_req;
  logic [DATA_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               dmem_req;
  logic               dmem_we;
  logic [DATA_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;
  logic [DATA_W-1:0]  pc;
  logic               instr_done;
  logic               wb_valid;
  logic [RA_W-1:0]    wb_addr;
  logic [DATA_W-1:0]  wb_data;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output pc, instr_done, wb_valid, wb_addr, wb_data,
    input  imem_ack, imem_data, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  pc, instr_done, wb_valid, wb_addr, wb_data,
    output imem_ack, imem_data, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_core_reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port, cleared on reset.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [RA_W-1:0]   ra_addr,
  input  logic [RA_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [RA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data
);
  localparam int NREGS = 2 ** RA_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[w_addr] = w_data;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
endmodule

// File: rtl/multicycle_core.sv
// Multicycle core: FETCH/DECODE/MEM/WB controller executing ADD, LD, ST and JMP
// over request/ack memory ports, with a register-file sub-module.
module multicycle_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  multicycle_core_if.master bus
);
  localparam int INSTR_W = instr_w(RA_W);

  function automatic logic signed [DATA_W-1:0] sext(input logic [RA_W-1:0] imm);
    return $signed({{(DATA_W-RA_W){imm[RA_W-1]}}, imm});
  endfunction

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        pc_q, pc_d;
  logic [INSTR_W-1:0]       ir_q, ir_d;
  logic signed [DATA_W-1:0] b_q, b_d;
  logic signed [DATA_W-1:0] aluout_q, aluout_d;
  logic signed [DATA_W-1:0] mdr_q, mdr_d;

  opcode_e                  op;
  logic [RA_W-1:0]          rs, rt, rd;
  logic signed [DATA_W-1:0] imm_ext, rf_a, rf_b;

  assign op      = opcode_e'(ir_q[INSTR_W-1 -: 2]);
  assign rs      = ir_q[3*RA_W-1 -: RA_W];
  assign rt      = ir_q[2*RA_W-1 -: RA_W];
  assign rd      = ir_q[RA_W-1:0];
  assign imm_ext = sext(rd);

  // Writes only happen in WB and reads only matter in DECODE, so no bypass is needed.
  reg_file #(.DATA_W(DATA_W), .RA_W(RA_W)) u_rf (
    .CLK     (CLK),
    .Reset   (Reset),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (bus.wb_valid),
    .w_addr  (bus.wb_addr),
    .w_data  (bus.wb_data)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        b_d      = rf_b;
        aluout_d = rf_a + ((op == OP_ADD) ? rf_b : imm_ext);
        unique case (op)
          OP_ADD:       state_d = S_WB;
          OP_LD, OP_ST: state_d = S_MEM;
          OP_JMP: begin
            pc_d    = pc_q + DATA_W'(1) + imm_ext;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (op == OP_LD) begin
            mdr_d   = $signed(bus.dmem_rdata);
            state_d = S_WB;
          end else begin
            pc_d    = pc_q + DATA_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_q + DATA_W'(1);
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are forced low while Reset is high so a pending access drops immediately.
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.imem_addr  = pc_q;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.pc         = pc_q;
    bus.instr_done = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    if (!Reset) begin
      unique case (state_q)
        S_FETCH:  bus.imem_req = 1'b1;
        S_DECODE: bus.instr_done = (op == OP_JMP);
        S_MEM: begin
          bus.dmem_req   = 1'b1;
          bus.dmem_we    = (op == OP_ST);
          bus.dmem_addr  = aluout_q;
          bus.dmem_wdata = b_q;
          bus.instr_done = bus.dmem_ack && (op == OP_ST);
        end
        S_WB: begin
          bus.wb_valid   = 1'b1;
          bus.wb_addr    = (op == OP_ADD) ? rd : rt;
          bus.wb_data    = (op == OP_ADD) ? aluout_q : mdr_q;
          bus.instr_done = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench: directed programs push expected fetch/memory/write-back/retire events,
// a negedge monitor pops and compares them; a second 16-bit instance checks the wide build.
module tb_multicycle_core;
  typedef enum int {K_FETCH, K_MEM, K_WB, K_DONE} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } ev_t;

  ev_t         exp_q[$];
  logic [18:0] exp2_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start = 0;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        rst2 = 1'b1;
  logic [7:0]  imem_m [256];
  int          dwait_m [256];
  logic [7:0]  rdata_m [256];
  logic [10:0] imem2 [16];

  multicycle_core_if #(.DATA_W(8),  .RA_W(2)) bus ();
  multicycle_core_if #(.DATA_W(16), .RA_W(3)) bus2 ();

  multicycle_core #(.DATA_W(8),  .RA_W(2)) dut  (.CLK(CLK), .Reset(Reset), .bus(bus));
  multicycle_core #(.DATA_W(16), .RA_W(3)) dut2 (.CLK(CLK), .Reset(rst2),  .bus(bus2));

  initial forever #5 CLK = ~CLK;

  // Zero-wait instruction memory for both cores; wide core also has zero-wait data memory.
  assign bus.imem_ack    = bus.imem_req;
  assign bus.imem_data   = imem_m[bus.imem_addr];
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_data  = imem2[bus2.imem_addr[3:0]];
  assign bus2.dmem_ack   = bus2.dmem_req;
  assign bus2.dmem_rdata = (bus2.dmem_addr == 16'h0001) ? 16'hFFFF : 16'h0002;

  // Data memory with per-instruction wait count and load data, keyed by the PC of the access.
  initial begin
    int dcnt;
    dcnt = 0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 8'h00;
    forever begin
      @(negedge CLK);
      if (bus.dmem_req && !bus.dmem_ack) begin
        if (dcnt == dwait_m[bus.pc]) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata_m[bus.pc];
        end else begin
          dcnt++;
        end
      end else begin
        bus.dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic ex(input kind_e k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back('{k, a, b, c});
  endtask

  task automatic observe(input kind_e k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: got a=%h b=%h c=%h", k.name(), a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b || e.c !== c) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h c=%h, required %s a=%h b=%h c=%h",
                 k.name(), a, b, c, e.kind.name(), e.a, e.b, e.c);
      end
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem_m[i]  = 8'hC3;
      dwait_m[i] = 0;
      rdata_m[i] = 8'h00;
    end
  endtask

  // Main monitor: fetch, completed data access, write-back and retire (with cycle latency).
  initial forever begin
    @(negedge CLK);
    #1;
    cyc++;
    if (!Reset) begin
      if (bus.imem_req && bus.imem_ack) begin
        start = cyc;
        observe(K_FETCH, bus.imem_addr, 8'h00, 8'h00);
      end
      if (bus.dmem_req && bus.dmem_ack)
        observe(K_MEM, {7'b0, bus.dmem_we}, bus.dmem_addr, bus.dmem_we ? bus.dmem_wdata : 8'h00);
      if (bus.wb_valid)
        observe(K_WB, {6'b0, bus.wb_addr}, bus.wb_data, 8'h00);
      if (bus.instr_done)
        observe(K_DONE, 8'(cyc - start + 1), 8'h00, 8'h00);
    end
  end

  initial forever begin
    logic [18:0] w;
    @(negedge CLK);
    #1;
    if (!rst2 && bus2.wb_valid) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL wide_wb unexpected: got addr=%0d data=%h", bus2.wb_addr, bus2.wb_data);
      end else begin
        w = exp2_q.pop_front();
        if ({bus2.wb_addr, bus2.wb_data} !== w) begin
          errors++;
          $display("FAIL wide_wb: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus2.wb_addr, bus2.wb_data, w[18:16], w[15:0]);
        end
      end
    end
  end

  initial begin
    int n;
    clear_mem();
    for (int i = 0; i < 16; i++) imem2[i] = 11'h607;
    imem2[0] = 11'h209;  // LD r1 = M[0+1]  = FFFF
    imem2[1] = 11'h212;  // LD r2 = M[0+2]  = 0002
    imem2[2] = 11'h053;  // ADD r3 = r1 + r2
    exp2_q.push_back({3'd1, 16'hFFFF});
    exp2_q.push_back({3'd2, 16'h0002});
    exp2_q.push_back({3'd3, 16'h0001});

    imem_m[0] = 8'h45; dwait_m[0] = 2; rdata_m[0] = 8'hA5;
    imem_m[1] = 8'h45; rdata_m[1] = 8'h03;
    imem_m[2] = 8'h4A; rdata_m[2] = 8'h05;
    imem_m[3] = 8'h1B;
    imem_m[4] = 8'h45; dwait_m[4] = 1; rdata_m[4] = 8'hFF;
    imem_m[5] = 8'h4A; rdata_m[5] = 8'h7E;
    imem_m[6] = 8'h1B;
    imem_m[7] = 8'h98; dwait_m[7] = 1;
    imem_m[8] = 8'h45; dwait_m[8] = 200;
    ex(K_FETCH, 8'h00, 8'h00, 8'h00); ex(K_MEM, 8'h00, 8'h01, 8'h00);
    ex(K_WB, 8'h01, 8'hA5, 8'h00);    ex(K_DONE, 8'd6, 8'h00, 8'h00);
    ex(K_FETCH, 8'h01, 8'h00, 8'h00); ex(K_MEM, 8'h00, 8'h01, 8'h00);
    ex(K_WB, 8'h01, 8'h03, 8'h00);    ex(K_DONE, 8'd4, 8'h00, 8'h00);
    ex(K_FETCH, 8'h02, 8'h00, 8'h00); ex(K_MEM, 8'h00, 8'hFE, 8'h00);
    ex(K_WB, 8'h02, 8'h05, 8'h00);    ex(K_DONE, 8'd4, 8'h00, 8'h00);
    ex(K_FETCH, 8'h03, 8'h00, 8'h00); ex(K_WB, 8'h03, 8'h08, 8'h00);
    ex(K_DONE, 8'd3, 8'h00, 8'h00);
    ex(K_FETCH, 8'h04, 8'h00, 8'h00); ex(K_MEM, 8'h00, 8'h01, 8'h00);
    ex(K_WB, 8'h01, 8'hFF, 8'h00);    ex(K_DONE, 8'd5, 8'h00, 8'h00);
    ex(K_FETCH, 8'h05, 8'h00, 8'h00); ex(K_MEM, 8'h00, 8'hFE, 8'h00);
    ex(K_WB, 8'h02, 8'h7E, 8'h00);    ex(K_DONE, 8'd4, 8'h00, 8'h00);
    ex(K_FETCH, 8'h06, 8'h00, 8'h00); ex(K_WB, 8'h03, 8'h7D, 8'h00);
    ex(K_DONE, 8'd3, 8'h00, 8'h00);
    ex(K_FETCH, 8'h07, 8'h00, 8'h00); ex(K_MEM, 8'h01, 8'hFF, 8'h7E);
    ex(K_DONE, 8'd4, 8'h00, 8'h00);
    ex(K_FETCH, 8'h08, 8'h00, 8'h00);

    #17;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_instr_done", bus.instr_done, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);

    @(negedge CLK);
    Reset = 1'b0;
    rst2  = 1'b0;
    #1;
    chk("first_fetch_req", bus.imem_req, 1);
    chk("first_fetch_addr", bus.imem_addr, 0);
    drain("drain_a", 200);

    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("hang_mem_req", bus.dmem_req, 1);
    chk("hang_pc", bus.pc, 8);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_dmem_req", bus.dmem_req, 0);
    chk("midrst_imem_req", bus.imem_req, 0);
    chk("midrst_pc", bus.pc, 0);
    chk("midrst_wb_valid", bus.wb_valid, 0);

    clear_mem();
    imem_m[0] = 8'h1B;
    imem_m[1] = 8'hC1;
    imem_m[3] = 8'hC1;
    imem_m[5] = 8'hC3;
    ex(K_FETCH, 8'h00, 8'h00, 8'h00); ex(K_WB, 8'h03, 8'h00, 8'h00);
    ex(K_DONE, 8'd3, 8'h00, 8'h00);
    ex(K_FETCH, 8'h01, 8'h00, 8'h00); ex(K_DONE, 8'd2, 8'h00, 8'h00);
    ex(K_FETCH, 8'h03, 8'h00, 8'h00); ex(K_DONE, 8'd2, 8'h00, 8'h00);
    ex(K_FETCH, 8'h05, 8'h00, 8'h00); ex(K_DONE, 8'd2, 8'h00, 8'h00);
    ex(K_FETCH, 8'h05, 8'h00, 8'h00);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("restart_fetch_req", bus.imem_req, 1);
    chk("restart_fetch_addr", bus.imem_addr, 0);
    drain("drain_b", 100);

    Reset = 1'b1;
    clear_mem();
    imem_m[0]     = 8'hC2;
    imem_m[8'hFF] = 8'h1B;
    ex(K_FETCH, 8'h00, 8'h00, 8'h00); ex(K_DONE, 8'd2, 8'h00, 8'h00);
    ex(K_FETCH, 8'hFF, 8'h00, 8'h00); ex(K_WB, 8'h03, 8'h00, 8'h00);
    ex(K_DONE, 8'd3, 8'h00, 8'h00);
    ex(K_FETCH, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    drain("drain_c", 100);
    Reset = 1'b1;

    n = 0;
    while (exp2_q.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    chk("wide_drain", exp2_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
